// File: rtl/window_streamer_pkg.sv
// window_streamer_pkg: shared defaults, FSM encoding and width helpers for the
// window_streamer block (raster pixel stream -> FxFxD sliding windows).
// Optional feature macro: WINDOW_STREAMER_SOF_CHECK_EN (in_sof / sof_err).
package window_streamer_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_D          = 3;
  localparam int DEF_H          = 96;
  localparam int DEF_W          = 96;
  localparam int DEF_F          = 3;

  // Counter width for a 0..n-1 range; never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ROW_W = cnt_w(DEF_H);
  localparam int DEF_COL_W = cnt_w(DEF_W);
  localparam int DEF_PIX_W = DEF_D * DEF_DATA_WIDTH;
  localparam int DEF_WIN_W = DEF_D * DEF_F * DEF_F * DEF_DATA_WIDTH;

  // S_FILL: top F-1 rows still loading, no output. S_RUN: windows emitted.
  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/window_streamer_if.sv
// window_streamer_if: pixel-in / window-out handshake bundle.
//   in_pixel/in_valid/in_ready : raster pixel stream, all D channels per beat
//   window/out_valid/out_ready : packed FxFxD receptive field
//   out_row/out_col            : top-left position of the emitted window
//   frame_done                 : last window of the frame handshaken
//   in_sof/sof_err             : only with WINDOW_STREAMER_SOF_CHECK_EN
// master = pixel source / window sink side, slave = window_streamer.
interface window_streamer_if #(
  parameter int DATA_WIDTH = window_streamer_pkg::DEF_DATA_WIDTH,
  parameter int D          = window_streamer_pkg::DEF_D,
  parameter int H          = window_streamer_pkg::DEF_H,
  parameter int W          = window_streamer_pkg::DEF_W,
  parameter int F          = window_streamer_pkg::DEF_F
) ();
  import window_streamer_pkg::*;

  localparam int PIX_W = D * DATA_WIDTH;
  localparam int WIN_W = D * F * F * DATA_WIDTH;
  localparam int ROW_W = cnt_w(H);
  localparam int COL_W = cnt_w(W);

  logic [PIX_W-1:0] in_pixel;
  logic             in_valid;
  logic             in_ready;
  logic [WIN_W-1:0] window;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic             frame_done;
`ifdef WINDOW_STREAMER_SOF_CHECK_EN
  logic             in_sof;
  logic             sof_err;
`endif

  modport master (
`ifdef WINDOW_STREAMER_SOF_CHECK_EN
    output in_sof, input sof_err,
`endif
    output in_pixel, in_valid, out_ready,
    input  in_ready, window, out_valid, out_row, out_col, frame_done
  );

  modport slave (
`ifdef WINDOW_STREAMER_SOF_CHECK_EN
    input in_sof, output sof_err,
`endif
    input  in_pixel, in_valid, out_ready,
    output in_ready, window, out_valid, out_row, out_col, frame_done
  );
endinterface

// File: rtl/window_streamer_line_ram.sv
// window_streamer_line_ram: one image line of pixels.
//   clk   : write clock
//   we    : write enable (synchronous)
//   addr  : shared read/write column address
//   wdata : pixel written at addr
//   rdata : combinational read of addr (old contents during a write cycle)
// Contents are never reset; the owner ignores them until they are filled.
module window_streamer_line_ram
  import window_streamer_pkg::*;
#(
  parameter int DEPTH = DEF_W,
  parameter int WIDTH = DEF_PIX_W
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [cnt_w(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/window_streamer.sv
// window_streamer: converts a raster pixel stream into FxFxD sliding windows
// using F-1 cascaded line buffers and an FxF window register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : window_streamer_if.slave (pixel in, window out, position,
//              frame_done; in_sof/sof_err with WINDOW_STREAMER_SOF_CHECK_EN)
// Window element (k,i,j) sits at ((k*F+i)*F+j)*DATA_WIDTH, i=0 top row,
// j=0 leftmost column. Single output stage: in_ready = !out_valid || out_ready.
module window_streamer
  import window_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int D          = DEF_D,
  parameter int H          = DEF_H,
  parameter int W          = DEF_W,
  parameter int F          = DEF_F
) (
  input logic               clk,
  input logic               rst,
  window_streamer_if.slave  bus
);
  localparam int PIX_W = D * DATA_WIDTH;
  localparam int WIN_W = D * F * F * DATA_WIDTH;
  localparam int ROW_W = cnt_w(H);
  localparam int COL_W = cnt_w(W);
  localparam int NLB   = F - 1;

  logic [ROW_W-1:0] row_q, row_d, eff_row;
  logic [COL_W-1:0] col_q, col_d, eff_col;
  state_e           state_q, state_d, eff_state;
  // win_q[j][i]: column j (0 = leftmost), row i (0 = top)
  logic [F-1:0][F-1:0][PIX_W-1:0] win_q, win_d;
  logic             out_valid_q, out_valid_d;
  logic             last_q, last_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [NLB-1:0][PIX_W-1:0] lb_rd, lb_wd;
  logic [WIN_W-1:0] win_pack;
  logic             accept, emit, resync;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef WINDOW_STREAMER_SOF_CHECK_EN
  logic sof_err_q, sof_err_d;
  // in_sof anywhere but (0,0) restarts the frame with this beat as (0,0)
  assign resync      = accept && bus.in_sof && ((row_q != '0) || (col_q != '0));
  assign sof_err_d   = resync;
  assign bus.sof_err = sof_err_q;
`else
  assign resync = 1'b0;
`endif

  // Position/state this beat is processed at (after any resync)
  assign eff_row   = resync ? '0 : row_q;
  assign eff_col   = resync ? '0 : col_q;
  assign eff_state = resync ? S_FILL : state_q;
  assign emit      = (eff_state == S_RUN) && (eff_col >= COL_W'(F - 1));

  // Cascade: line 0 takes the new pixel, line L takes what line L-1 held.
  for (genvar l = 0; l < NLB; l++) begin : g_lb
    if (l == 0) begin : g_head
      assign lb_wd[l] = bus.in_pixel;
    end else begin : g_tail
      assign lb_wd[l] = lb_rd[l-1];
    end
    window_streamer_line_ram #(.DEPTH(W), .WIDTH(PIX_W)) u_line (
      .clk   (clk),
      .we    (accept),
      .addr  (eff_col),
      .wdata (lb_wd[l]),
      .rdata (lb_rd[l])
    );
  end

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    state_d     = state_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    last_d      = last_q;
    if (accept) begin
      for (int j = 0; j < F - 1; j++) win_d[j] = win_q[j+1];
      // newest column, top to bottom: oldest line ... line 0, live pixel
      for (int i = 0; i < F - 1; i++) win_d[F-1][i] = lb_rd[F-2-i];
      win_d[F-1][F-1] = bus.in_pixel;

      state_d = eff_state;
      if (eff_col == COL_W'(W - 1)) begin
        col_d = '0;
        row_d = (eff_row == ROW_W'(H - 1)) ? '0 : eff_row + 1'b1;
        if (eff_row == ROW_W'(F - 2))      state_d = S_RUN;
        else if (eff_row == ROW_W'(H - 1)) state_d = S_FILL;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end

      // An accepted beat always replaces (or drops) the held window.
      out_valid_d = emit;
      if (emit) begin
        out_row_d = eff_row - ROW_W'(F - 1);
        out_col_d = eff_col - COL_W'(F - 1);
        last_d    = (eff_row == ROW_W'(H - 1)) && (eff_col == COL_W'(W - 1));
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      state_q     <= S_FILL;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      last_q      <= 1'b0;
`ifdef WINDOW_STREAMER_SOF_CHECK_EN
      sof_err_q   <= 1'b0;
`endif
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      state_q     <= state_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      last_q      <= last_d;
`ifdef WINDOW_STREAMER_SOF_CHECK_EN
      sof_err_q   <= sof_err_d;
`endif
    end
  end

  // Repack to channel-major, then row, then column.
  always_comb begin
    win_pack = '0;
    for (int k = 0; k < D; k++)
      for (int i = 0; i < F; i++)
        for (int j = 0; j < F; j++)
          win_pack[((k*F+i)*F+j)*DATA_WIDTH +: DATA_WIDTH] = win_q[j][i][k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign bus.window     = win_pack;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.frame_done = out_valid_q && bus.out_ready && last_q;
endmodule

// File: tb/tb_window_streamer.sv
// tb_window_streamer: directed bench for window_streamer on a 5x4 image,
// F=3, D=3, channel k sample = 100*k + (r*5+c).
// Optional feature macro: WINDOW_STREAMER_SOF_CHECK_EN (adds sof test).
module tb_window_streamer;
  localparam int DW = 8, D = 3, H = 4, W = 5, F = 3;
  localparam int PIX_W = D * DW;
  localparam int WIN_W = D * F * F * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window_streamer_if #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W), .F(F)) bus ();

  window_streamer #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W), .F(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0, failures = 0, stalls = 0, fd_count = 0;
  logic [WIN_W-1:0] q_win[$];
  int q_row[$], q_col[$];
  bit q_fd[$];

  // Record every handshaken window mid-cycle, when inputs are settled.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      q_win.push_back(bus.window);
      q_row.push_back(int'(bus.out_row));
      q_col.push_back(int'(bus.out_col));
      q_fd.push_back(bus.frame_done);
    end
    if (!rst && bus.frame_done) fd_count++;
  end

  function automatic logic [PIX_W-1:0] mk(input int p);
    logic [PIX_W-1:0] v;
    for (int k = 0; k < D; k++) v[k*DW +: DW] = 8'(100*k + p);
    return v;
  endfunction

  function automatic logic [WIN_W-1:0] exp_win(input int r0, input int c0);
    logic [WIN_W-1:0] v;
    v = '0;
    for (int k = 0; k < D; k++)
      for (int i = 0; i < F; i++)
        for (int j = 0; j < F; j++)
          v[((k*F+i)*F+j)*DW +: DW] = 8'(100*k + (r0+i)*W + c0 + j);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel and hold it until accepted (bounded).
  task automatic beat(input int pix, input bit sof);
    bit acc;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_pixel = mk(pix);
`ifdef WINDOW_STREAMER_SOF_CHECK_EN
    bus.in_sof = sof;
`endif
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      stalls++;
      if (n > 100) begin
        chk("accept_timeout", WIN_W'(n), '0);
        break;
      end
    end
    bus.in_valid = 1'b0;
`ifdef WINDOW_STREAMER_SOF_CHECK_EN
    bus.in_sof = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    q_win.delete(); q_row.delete(); q_col.delete(); q_fd.delete();
  endtask

  // Six windows in raster order starting at queue index base.
  task automatic check_frame(input int base, input string tag);
    int r, c;
    checks++;
    assert (q_win.size() >= base + 6) else begin
      failures++;
      $error("FAIL %s_count observed=%0d expected>=%0d", tag, q_win.size(), base + 6);
    end
    if (q_win.size() >= base + 6) begin
      for (int n = 0; n < 6; n++) begin
        r = n / 3;
        c = n % 3;
        chk($sformatf("%s_win%0d", tag, n), q_win[base+n], exp_win(r, c));
        chk($sformatf("%s_row%0d", tag, n), WIN_W'(q_row[base+n]), WIN_W'(r));
        chk($sformatf("%s_col%0d", tag, n), WIN_W'(q_col[base+n]), WIN_W'(c));
        chk($sformatf("%s_fd%0d", tag, n), WIN_W'(q_fd[base+n]), WIN_W'(n == 5));
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b1;
`ifdef WINDOW_STREAMER_SOF_CHECK_EN
    bus.in_sof = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", WIN_W'(bus.out_valid), '0);
    chk("rst_window", bus.window, '0);
    chk("rst_out_row", WIN_W'(bus.out_row), '0);
    chk("rst_out_col", WIN_W'(bus.out_col), '0);
    chk("rst_frame_done", WIN_W'(bus.frame_done), '0);
    chk("rst_in_ready", WIN_W'(bus.in_ready), WIN_W'(1));
    rst = 1'b0;
    idle(1);

    // Single frame, always ready
    clear_q(); stalls = 0; fd_count = 0;
    for (int p = 0; p < 12; p++) beat(p, 1'b0);
    chk("t1_no_valid_before_13", WIN_W'(bus.out_valid), '0);
    beat(12, 1'b0);
    chk("t1_first_valid", WIN_W'(bus.out_valid), WIN_W'(1));
    chk("t1_first_window", bus.window, exp_win(0, 0));
    chk("t1_first_pos", WIN_W'({bus.out_row, bus.out_col}), '0);
    for (int p = 13; p < 20; p++) beat(p, 1'b0);
    idle(3);
    chk("t1_count", WIN_W'(q_win.size()), WIN_W'(6));
    check_frame(0, "t1");
    chk("t1_fd_pulses", WIN_W'(fd_count), WIN_W'(1));
    chk("t1_no_stall", WIN_W'(stalls), '0);
    chk("t1_idle_valid", WIN_W'(bus.out_valid), '0);

    // Backpressure at the second window
    clear_q();
    for (int p = 0; p < 14; p++) beat(p, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pixel  = mk(14);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk($sformatf("t2_in_ready%0d", n), WIN_W'(bus.in_ready), '0);
      chk($sformatf("t2_valid%0d", n), WIN_W'(bus.out_valid), WIN_W'(1));
      chk($sformatf("t2_window%0d", n), bus.window, exp_win(0, 1));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    for (int p = 14; p < 20; p++) beat(p, 1'b0);
    idle(3);
    chk("t2_count", WIN_W'(q_win.size()), WIN_W'(6));
    check_frame(0, "t2");

    // Two back-to-back frames
    clear_q(); stalls = 0; fd_count = 0;
    for (int p = 0; p < 40; p++) begin
      beat(p % 20, 1'b0);
      if (p == 30) chk("t3_no_win_col0", WIN_W'(bus.out_valid), '0);
      if (p == 31) chk("t3_no_win_col1", WIN_W'(bus.out_valid), '0);
    end
    idle(3);
    chk("t3_count", WIN_W'(q_win.size()), WIN_W'(12));
    check_frame(0, "t3a");
    check_frame(6, "t3b");
    chk("t3_fd_pulses", WIN_W'(fd_count), WIN_W'(2));
    chk("t3_no_stall", WIN_W'(stalls), '0);

    // Reset mid-frame, then a fresh frame
    for (int p = 0; p < 8; p++) beat(p, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", WIN_W'(bus.out_valid), '0);
    chk("t5_rst_window", bus.window, '0);
    chk("t5_rst_pos", WIN_W'({bus.out_row, bus.out_col}), '0);
    chk("t5_rst_fd", WIN_W'(bus.frame_done), '0);
    rst = 1'b0;
    idle(1);
    clear_q();
    for (int p = 0; p < 20; p++) beat(p, 1'b0);
    idle(3);
    chk("t5_count", WIN_W'(q_win.size()), WIN_W'(6));
    check_frame(0, "t5");

`ifdef WINDOW_STREAMER_SOF_CHECK_EN
    // Unexpected in_sof on the 8th beat restarts the frame there
    clear_q();
    beat(0, 1'b1);
    chk("t6_sof_ok", WIN_W'(bus.sof_err), '0);
    for (int p = 1; p < 7; p++) beat(p, 1'b0);
    beat(0, 1'b1);
    chk("t6_sof_err", WIN_W'(bus.sof_err), WIN_W'(1));
    beat(1, 1'b0);
    chk("t6_sof_pulse", WIN_W'(bus.sof_err), '0);
    for (int p = 2; p < 20; p++) beat(p, 1'b0);
    idle(3);
    chk("t6_count", WIN_W'(q_win.size()), WIN_W'(6));
    check_frame(0, "t6");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
